// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and flag bit positions for alu_seq.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned FLAG_Z    = 0;
  localparam int unsigned FLAG_N    = 1;
  localparam int unsigned FLAG_C    = 2;
  localparam int unsigned FLAG_V    = 3;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier. Always takes exactly WIDTH cycles from start to done;
// bit 0 of B is consumed on the start edge itself.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               w_last;

  assign w_last = (r_cnt == CW'(WIDTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= CW'(1);
      r_acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
      r_mcand  <= {{WIDTH{1'b0}}, A} << 1;
      r_mplier <= B >> 1;
    end else if (r_busy) begin
      // Hold the finished product for one cycle so the top can capture it with done.
      if (w_last) begin
        r_busy <= 1'b0;
      end else begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  assign done = r_busy && w_last;
  assign prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with NZCV flags, shifts and an optional iterative multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inTwo,
  input  logic [3:0]       opcode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             carryBit,
  output logic             ovfFlag
);

  state_e               r_state;
  state_e               w_state_d;
  logic [WIDTH-1:0]     r_result;
  logic [NUM_FLAGS-1:0] r_flags;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_alu_res;
  logic [NUM_FLAGS-1:0] w_alu_flags;
  logic [WIDTH-1:0]     w_mul_res;
  logic [NUM_FLAGS-1:0] w_mul_flags;

  assign inReady     = (r_state == IDLE) || ((r_state == DONE) && outReady);
  assign w_accept    = inValid && inReady;
  assign w_is_mul    = MUL_EN && (opcode == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  assign w_sum  = {1'b0, inOne} + {1'b0, inTwo};
  assign w_diff = {1'b0, inOne} - {1'b0, inTwo};

  // Single-cycle datapath: computed from the live inputs and captured on the accept edge.
  always_comb begin
    w_alu_res   = '0;
    w_alu_flags = '0;
    case (opcode)
      OP_ADD: begin
        w_alu_res           = w_sum[WIDTH-1:0];
        w_alu_flags[FLAG_C] = w_sum[WIDTH];
        w_alu_flags[FLAG_V] = (inOne[WIDTH-1] == inTwo[WIDTH-1]) &&
                              (w_sum[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res           = w_diff[WIDTH-1:0];
        w_alu_flags[FLAG_C] = w_diff[WIDTH];
        w_alu_flags[FLAG_V] = (inOne[WIDTH-1] != inTwo[WIDTH-1]) &&
                              (w_diff[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_CBZ:  w_alu_res = {{(WIDTH-1){1'b0}}, (inTwo == '0)};
      OP_AND:  w_alu_res = inOne & inTwo;
      OP_OR:   w_alu_res = inOne | inTwo;
      OP_XOR:  w_alu_res = inOne ^ inTwo;
      OP_NOR:  w_alu_res = ~(inOne | inTwo);
      OP_NAND: w_alu_res = ~(inOne & inTwo);
      OP_MOV:  w_alu_res = inOne;
      OP_LSL:  w_alu_res = inOne << inTwo[SHW-1:0];
      OP_LSR:  w_alu_res = inOne >> inTwo[SHW-1:0];
      default: w_alu_res = '0;
    endcase
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
  end

  always_comb begin
    w_mul_res           = w_prod[WIDTH-1:0];
    w_mul_flags         = '0;
    w_mul_flags[FLAG_Z] = (w_mul_res == '0);
    w_mul_flags[FLAG_N] = w_mul_res[WIDTH-1];
    w_mul_flags[FLAG_C] = |w_prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_d = w_is_mul ? BUSY : DONE;
      end
      BUSY: begin
        if (w_mul_done) w_state_d = DONE;
      end
      DONE: begin
        if (outReady) begin
          if (w_accept) w_state_d = w_is_mul ? BUSY : DONE;
          else          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept && !w_is_mul) begin
        r_result <= w_alu_res;
        r_flags  <= w_alu_flags;
      end else if ((r_state == BUSY) && w_mul_done) begin
        r_result <= w_mul_res;
        r_flags  <= w_mul_flags;
      end
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_iter #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clock(clock),
        .reset(reset),
        .start(w_mul_start),
        .A    (inOne),
        .B    (inTwo),
        .done (w_mul_done),
        .prod (w_prod)
      );
    end else begin : g_no_mul
      assign w_mul_done = 1'b0;
      assign w_prod     = '0;
    end
  endgenerate

  assign outValid = (r_state == DONE);
  assign result   = r_result;
  assign zeroFlag = r_flags[FLAG_Z];
  assign negFlag  = r_flags[FLAG_N];
  assign carryBit = r_flags[FLAG_C];
  assign ovfFlag  = r_flags[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: one instance with the multiplier, one built without it.
module tb_alu_seq;

  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b1010;
  localparam logic [3:0] CBZ  = 4'b0111;
  localparam logic [3:0] ANDO = 4'b0110;
  localparam logic [3:0] ORO  = 4'b0100;
  localparam logic [3:0] XORO = 4'b1001;
  localparam logic [3:0] NORO = 4'b0101;
  localparam logic [3:0] NAND = 4'b1100;
  localparam logic [3:0] MOV  = 4'b1101;
  localparam logic [3:0] LSL  = 4'b0011;
  localparam logic [3:0] LSR  = 4'b1000;
  localparam logic [3:0] MUL  = 4'b1011;
  localparam logic [3:0] UNDF = 4'b1111;

  logic        clock;
  logic        reset;
  logic        inValid, inReady, outValid, outReady;
  logic [31:0] inOne, inTwo, result;
  logic [3:0]  opcode;
  logic        zeroFlag, negFlag, carryBit, ovfFlag;
  logic [3:0]  flags;

  logic        inValid_b, inReady_b, outValid_b, outReady_b;
  logic [31:0] inOne_b, inTwo_b, result_b;
  logic [3:0]  opcode_b;
  logic        zeroFlag_b, negFlag_b, carryBit_b, ovfFlag_b;
  logic [3:0]  flags_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Flags packed as {V, C, N, Z}.
  assign flags   = {ovfFlag, carryBit, negFlag, zeroFlag};
  assign flags_b = {ovfFlag_b, carryBit_b, negFlag_b, zeroFlag_b};

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clock   (clock),
    .reset   (reset),
    .inValid (inValid),
    .inReady (inReady),
    .inOne   (inOne),
    .inTwo   (inTwo),
    .opcode  (opcode),
    .outValid(outValid),
    .outReady(outReady),
    .result  (result),
    .zeroFlag(zeroFlag),
    .negFlag (negFlag),
    .carryBit(carryBit),
    .ovfFlag (ovfFlag)
  );

  alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clock   (clock),
    .reset   (reset),
    .inValid (inValid_b),
    .inReady (inReady_b),
    .inOne   (inOne_b),
    .inTwo   (inTwo_b),
    .opcode  (opcode_b),
    .outValid(outValid_b),
    .outReady(outReady_b),
    .result  (result_b),
    .zeroFlag(zeroFlag_b),
    .negFlag (negFlag_b),
    .carryBit(carryBit_b),
    .ovfFlag (ovfFlag_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    inValid = 1'b1;
    opcode  = op;
    inOne   = a;
    inTwo   = b;
    step();
    inValid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
    run_op(op, a, b);
    check({tag, "_valid"}, 32'(outValid), 32'd1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_flags"}, 32'(flags), 32'(exp_f));
    step();
  endtask

  // Counts edges after the accept edge until outValid; expects exactly WIDTH (33 incl. accept).
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_f);
    int  n;
    bit  ready_seen;
    n          = 0;
    ready_seen = 1'b0;
    run_op(MUL, a, b);
    while (!outValid && n < 100) begin
      if (inReady) ready_seen = 1'b1;
      step();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd32);
    check({tag, "_ready_in_busy"}, 32'(ready_seen), 32'd0);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_flags"}, 32'(flags), 32'(exp_f));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    inValid    = 1'b0;
    inOne      = '0;
    inTwo      = '0;
    opcode     = '0;
    outReady   = 1'b1;
    inValid_b  = 1'b0;
    inOne_b    = '0;
    inTwo_b    = '0;
    opcode_b   = '0;
    outReady_b = 1'b1;
    step();
    step();
    check("reset_valid", 32'(outValid), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", 32'(flags), 32'h0);
    check("reset_ready", 32'(inReady), 32'd1);
    reset = 1'b0;
    step();

    single("add_wrap", ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0101);
    single("add_ovf", ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1010);
    single("sub_borrow", SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 4'b0110);
    single("sub_ovf", SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 4'b1000);
    single("nor", NORO, 32'h0, 32'h0, 32'hFFFF_FFFF, 4'b0010);
    single("nand", NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 4'b0001);
    single("and", ANDO, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'b0000);
    single("or", ORO, 32'hF0, 32'h0F, 32'hFF, 4'b0000);
    single("cbz_zero", CBZ, 32'h5, 32'h0, 32'h1, 4'b0000);
    single("cbz_nz", CBZ, 32'h5, 32'h7, 32'h0, 4'b0001);
    single("mov", MOV, 32'h1234_5678, 32'h0, 32'h1234_5678, 4'b0000);
    single("lsl_mask", LSL, 32'h1, 32'h24, 32'h10, 4'b0000);
    single("lsr_31", LSR, 32'h8000_0000, 32'h1F, 32'h1, 4'b0000);
    single("lsr_logical", LSR, 32'hF000_0000, 32'h4, 32'h0F00_0000, 4'b0000);
    single("undef", UNDF, 32'h55, 32'hAA, 32'h0, 4'b0001);

    mul_op("mul_ovf", 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0101);
    mul_op("mul_small", 32'h3, 32'h5, 32'hF, 4'b0000);
    mul_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 4'b0100);
    mul_op("mul_zero", 32'h0, 32'h7, 32'h0, 4'b0001);

    // Back-pressure: result must hold and later input changes must not leak in.
    outReady = 1'b0;
    run_op(XORO, 32'hF0, 32'h0F);
    inOne  = 32'hDEAD_BEEF;
    opcode = ADD;
    for (int i = 0; i < 5; i++) begin
      check("hold_result", result, 32'hFF);
      check("hold_valid", 32'(outValid), 32'd1);
      check("hold_ready", 32'(inReady), 32'd0);
      step();
    end
    outReady = 1'b1;
    inValid  = 1'b1;
    opcode   = MOV;
    for (int i = 0; i < 8; i++) begin
      inOne = 32'h100 + 32'(i);
      step();
      check("b2b_result", result, 32'h100 + 32'(i));
      check("b2b_valid", 32'(outValid), 32'd1);
    end
    inValid = 1'b0;
    step();
    check("b2b_idle", 32'(outValid), 32'd0);

    // Reset in the middle of a multiply.
    run_op(MUL, 32'h7, 32'h9);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_busy_valid", 32'(outValid), 32'd0);
    check("rst_busy_result", result, 32'h0);
    check("rst_busy_ready", 32'(inReady), 32'd1);
    single("add_after_rst", ADD, 32'h2, 32'h2, 32'h4, 4'b0000);
    mul_op("mul_after_rst", 32'h6, 32'h7, 32'd42, 4'b0000);

    // Instance without the multiplier.
    inValid_b = 1'b1;
    opcode_b  = MUL;
    inOne_b   = 32'h3;
    inTwo_b   = 32'h4;
    step();
    inValid_b = 1'b0;
    check("nomul_valid", 32'(outValid_b), 32'd1);
    check("nomul_result", result_b, 32'h0);
    check("nomul_flags", 32'(flags_b), 32'b0001);
    step();
    inValid_b = 1'b1;
    opcode_b  = UNDF;
    inOne_b   = 32'h3;
    inTwo_b   = 32'h4;
    step();
    inValid_b = 1'b0;
    check("nomul_undef_result", result_b, 32'h0);
    check("nomul_undef_zero", 32'(zeroFlag_b), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU. Operand width is configurable, results and flags are registered, and a valid/ready interface sits on both sides.
- Adds NZCV flags computed on the result, logical shifts, and an optional iterative multiplier that takes multiple cycles.
- Sits between Decoder & Control (operand/opcode producer) and the Data Cache / writeback stage (result consumer).

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, minimum 8.
- MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL treated as undefined opcode.
- SHW, $clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
- clock  in  1  main clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  operands/opcode valid.
- inReady  out  1  block can accept a new operation.
- inOne  in  WIDTH  operand A.
- inTwo  in  WIDTH  operand B.
- opcode  in  4  ALU control code.
- outValid  out  1  result/flags valid.
- outReady  in  1  consumer accepts result.
- result  out  WIDTH  operation result.
- zeroFlag  out  1  result == 0.
- negFlag  out  1  result[WIDTH-1].
- carryBit  out  1  carry/borrow/multiply-overflow.
- ovfFlag  out  1  signed overflow (ADD/SUB only).

Behaviour:
- Reset (clock edge with reset=1):
  - State goes to IDLE.
  - result=0, all flags=0, outValid=0.
  - Any in-flight MUL is aborted and discarded.
  - reset overrides every other input on that edge.
- Accept rule:
  - An operation is accepted on an edge where inValid && inReady.
  - inOne, inTwo and opcode are latched on accept; later input changes have no effect.
- inReady = (state==IDLE) || (state==DONE && outReady). This allows back-to-back single-cycle ops at 1 op/cycle.
- States:
  - IDLE: on accept of a single-cycle op, go to DONE. On accept of MUL (MUL_EN=1), go to BUSY.
  - BUSY: multiplier runs exactly WIDTH cycles, then goes to DONE. inReady=0. Incoming requests stall and are not dropped.
  - DONE: outValid=1; result and flags stay stable until outReady=1.
    - outReady && accept: start the new op (DONE or BUSY).
    - outReady && !accept: go to IDLE.
- Latency from accept to outValid: 1 cycle for single-cycle ops; WIDTH+1 cycles for MUL.
- Opcodes (unchanged encodings preserved):
  - 0010 ADD: {c,r}=A+B, carry=c.
  - 1010 SUB: {c,r}=A-B, carry=borrow (1 when A<B unsigned).
  - 0111 CBZ: r = (B==0) zero-extended.
  - 0110 AND; 0100 OR; 1001 XOR.
  - 0101 NOR = ~(A|B), bitwise. 1100 NAND = ~(A&B), bitwise.
  - 1101 MOV: r=A.
  - 0011 LSL: r = A << B[SHW-1:0]. 1000 LSR: r = A >> B[SHW-1:0], logical. Upper bits of B are ignored.
  - 1011 MUL: r = low WIDTH bits of unsigned A*B; carry=1 when the high WIDTH bits are nonzero.
  - Any other code, or MUL with MUL_EN=0: r=0, 1-cycle latency.
- Flags:
  - zeroFlag and negFlag derive from the registered result for every op.
  - ovfFlag is valid for ADD/SUB (two's-complement overflow) and is 0 otherwise.
  - carryBit is 0 for all ops except ADD/SUB/MUL.
  - All flags are registered together with result.
- MUL boundary cases:
  - A=0 or B=0 still takes WIDTH cycles; no early exit, so latency is deterministic.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ADD, OP_SUB, OP_CBZ, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_MOV, OP_LSL, OP_LSR, OP_MUL);
  - state encoding (IDLE, BUSY, DONE);
  - flag bit index constants.
- Sub-module alu_mul_iter: shift-add multiplier.
  - Ports: start, A, B, done, prod[2*WIDTH-1:0].
  - Generated only when MUL_EN=1.

Test Plan:
- WIDTH=32, ADD A=0xFFFFFFFF B=1 -> 1 cycle later outValid=1, result=0, carryBit=1, zeroFlag=1, ovfFlag=0.
- ADD A=0x7FFFFFFF B=1 -> result=0x80000000, negFlag=1, ovfFlag=1, carryBit=0.
- SUB A=3 B=5 -> result=0xFFFFFFFE, carryBit=1, negFlag=1.
- NOR A=0 B=0 -> result=0xFFFFFFFF (bitwise).
- MUL A=0x10000 B=0x10000 -> outValid exactly 33 cycles after accept, result=0, carryBit=1, zeroFlag=1; inReady=0 throughout BUSY.
- Hold outReady=0 for 5 cycles after an XOR 0xF0^0x0F result -> result=0xFF stable, inReady=0. Then 8 back-to-back MOVs with outReady=1 -> one result per cycle, in order.
- Assert reset during BUSY of a MUL -> next cycle outValid=0, result=0, inReady=1; the subsequent ADD 2+2 returns 4.
- MUL_EN=0: MUL 3*4 -> result=0 after 1 cycle. Opcode 1111 -> result=0, zeroFlag=1.
